max7219_frame_ctrl: RTL

//  Frame sequencer for the MAX7219 serial link. Sits between the SCK clock divider
//  (sck/sck_edge) and the pins: accepts a 16*CHAIN-bit word over valid/ready, gates the

---
 rtl/max7219_frame_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/max7219_frame_ctrl.sv
// ---------------------------------------------------------------------------
// max7219_frame_ctrl
//   Frame sequencer for a MAX7219 serial link. Accepts a 16*CHAIN-bit word over a
//   valid/ready handshake. It gates the free-running divided clock onto max_clk for
//   exactly 16*CHAIN rising edges and shifts max_din MSB-first. When the frame is done
//   it raises max_load_n to latch the data in the chips.
//
//   Optional feature: define MAX7219_INIT_SEQ_EN to send a five-frame power-up
//   init sequence (normal op, scan 8 digits, no decode, intensity, test off)
//   before the first user frame is accepted.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   sck_in       divided clock from the SCK divider (free-running)
//   sck_edge     1-cycle strobe in the first clk cycle of sck_in high
//   tx_data      frame; top 16 bits are destined for the last chip in the chain
//   tx_valid     frame request
//   tx_ready     frame can be accepted this cycle
//   busy         frame (or init sequence) in flight
//   frame_done   1-cycle pulse when a frame has been latched
//   max_clk      sck_in gated by a registered enable
//   max_din      serial data, updated only just after sck_in falls
//   max_load_n   LOAD/CS: low while shifting, rising edge latches
// ---------------------------------------------------------------------------
module max7219_frame_ctrl #(
  parameter int         CHAIN          = 1,
  parameter logic [3:0] INIT_INTENSITY = 4'h7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck_in,
  input  logic                  sck_edge,
  input  logic [16*CHAIN-1:0]   tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  max_clk,
  output logic                  max_din,
  output logic                  max_load_n
);

  localparam int                NBITS    = 16 * CHAIN;
  localparam int                CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NBITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_SHIFT,
    S_LATCH
  } state_e;

`ifdef MAX7219_INIT_SEQ_EN
  localparam logic       RST_READY   = 1'b0;
  localparam logic       RST_BUSY    = 1'b1;
  localparam logic [2:0] INIT_FRAMES = 3'd5;

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = 16'h0C01;
      3'd1:    init_word = 16'h0B07;
      3'd2:    init_word = 16'h0900;
      3'd3:    init_word = {12'h0A0, INIT_INTENSITY};
      default: init_word = 16'h0F00;
    endcase
  endfunction

  logic [2:0] init_idx_q, init_idx_d;
`else
  localparam logic RST_READY = 1'b1;
  localparam logic RST_BUSY  = 1'b0;
`endif

  state_e             state_q,  state_d;
  logic [NBITS-1:0]   shreg_q,  shreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic               sck_q;
  logic               din_q,    din_d;
  logic               load_n_q, load_n_d;
  logic               gate_q,   gate_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               ready_q,  ready_d;
  logic               sck_fall;

  // One-cycle strobe in the first clk cycle of sck_in low.
  assign sck_fall = sck_q & ~sck_in;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch); branches below only override what changes.
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    din_d    = din_q;
    load_n_d = load_n_q;
    gate_d   = gate_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
`ifdef MAX7219_INIT_SEQ_EN
    init_idx_d = init_idx_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef MAX7219_INIT_SEQ_EN
        if (init_idx_q != INIT_FRAMES) begin
          shreg_d = {CHAIN{init_word(init_idx_q)}};
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = S_ALIGN;
        end else
`endif
        if (tx_valid && ready_q) begin
          shreg_d = tx_data;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ALIGN;
        end else begin
          // Rises one cycle after frame_done because the IDLE entry cycle sets it.
          ready_d = 1'b1;
        end
      end

      S_ALIGN: begin
        // Start on a falling edge so DIN and the gate settle while sck_in is low.
        if (sck_fall) begin
          load_n_d = 1'b0;
          din_d    = shreg_q[NBITS-1];
          gate_d   = 1'b1;
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (sck_edge) begin
          bitcnt_d = bitcnt_q + 1'b1;
        end else if (sck_fall) begin
          if (bitcnt_q == LAST_CNT) begin
            gate_d   = 1'b0;
            load_n_d = 1'b1;
            din_d    = 1'b0;
            state_d  = S_LATCH;
          end else begin
            shreg_d = shreg_q << 1;
            din_d   = shreg_q[NBITS-2];
          end
        end
      end

      S_LATCH: begin
        // Keep LOAD high through a full sck-low half-period before reporting done.
        if (sck_edge) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef MAX7219_INIT_SEQ_EN
          if (init_idx_q != INIT_FRAMES) begin
            init_idx_d = init_idx_q + 3'd1;
            busy_d     = (init_idx_q != INIT_FRAMES - 3'd1);
          end
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      // NOTE: the shift register is reset along with the control flops so a
      // frame abandoned by reset can never leak stale bits into the next one.
      shreg_q  <= '0;
      bitcnt_q <= '0;
      sck_q    <= 1'b0;
      din_q    <= 1'b0;
      load_n_q <= 1'b1;
      gate_q   <= 1'b0;
      busy_q   <= RST_BUSY;
      done_q   <= 1'b0;
      ready_q  <= RST_READY;
`ifdef MAX7219_INIT_SEQ_EN
      init_idx_q <= 3'd0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      sck_q    <= sck_in;
      din_q    <= din_d;
      load_n_q <= load_n_d;
      gate_q   <= gate_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
`ifdef MAX7219_INIT_SEQ_EN
      init_idx_q <= init_idx_d;
`endif
    end
  end

  // The gate only changes while sck_in is low, so the AND cannot produce a runt.
  assign max_clk    = sck_in & gate_q;
  assign max_din    = din_q;
  assign max_load_n = load_n_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign tx_ready   = ready_q;

endmodule
